// File: rtl/sdspi_pkg.sv
// Shared types and constants for the SD-card SPI command sequencer.
package sdspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TX     = 3'd1,
        ST_POLL   = 3'd2,
        ST_RXDATA = 3'd3,
        ST_DONE   = 3'd4
    } sdspi_state_t;

    localparam int unsigned TX_BYTES       = 6;
    localparam int unsigned RX_EXTRA_BYTES = 4;

    localparam logic [7:0] POLL_BYTE  = 8'hFF;
    localparam logic [1:0] START_BITS = 2'b01;
    localparam logic       STOP_BIT   = 1'b1;

    // First byte of a command frame: start bits followed by the index.
    function automatic logic [7:0] cmd_token(input logic [5:0] cmd);
        return {START_BITS, cmd};
    endfunction

endpackage

// File: rtl/sdspi_crc7.sv
// One-byte step of the SD command CRC7 (x^7 + x^3 + 1), MSB first.
// Only present when SDSPI_CMD_CRC7_EN is defined.
`ifdef SDSPI_CMD_CRC7_EN
module sdspi_crc7 (
    input  logic [7:0] i_data,
    input  logic [6:0] i_crc,
    output logic [6:0] o_crc
);

    logic [6:0] w_acc;

    // Shift the eight data bits through the LFSR, MSB first.
    always_comb begin
        w_acc = i_crc;
        for (int i = 7; i >= 0; i--) begin
            if (i_data[i] ^ w_acc[6]) begin
                w_acc = {w_acc[5:0], 1'b0} ^ 7'h09;
            end else begin
                w_acc = {w_acc[5:0], 1'b0};
            end
        end
        o_crc = w_acc;
    end

endmodule
`endif

// File: rtl/sdspi_cmd_seq.sv
// SD-card SPI command sequencer: sends a 6-byte command frame through a
// byte engine, polls for R1, optionally reads 4 extra response bytes.
// Optional macro SDSPI_CMD_CRC7_EN: compute the real CRC7 for the last
// frame byte; otherwise that byte is the constant 8'hFF.
module sdspi_cmd_seq
    import sdspi_pkg::*;
#(
    parameter int unsigned MAX_POLL = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_stb,
    input  logic [5:0]  i_cmd,
    input  logic [31:0] i_arg,
    input  logic        i_rsp_extra,
    input  logic        i_hold_cs,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_r1,
    output logic [31:0] o_rsp_data,
    output logic        o_timeout,
    output logic        o_ll_cs,
    output logic        o_ll_stb,
    output logic [7:0]  o_ll_byte,
    input  logic        i_ll_idle,
    input  logic        i_ll_stb,
    input  logic [7:0]  i_ll_byte
);

    localparam int unsigned         TX_CNT_W  = 3;
    localparam logic [TX_CNT_W-1:0] TX_LAST   = TX_CNT_W'(TX_BYTES - 1);
    localparam logic [7:0]          POLL_LAST = 8'(MAX_POLL - 1);
    localparam logic [7:0]          RX_LAST   = 8'(RX_EXTRA_BYTES - 1);
    localparam logic [7:0]          CNT_MAX   = 8'hFF;

    sdspi_state_t        r_state;
    logic [5:0]          r_cmd;
    logic [31:0]         r_arg;
    logic                r_extra;
    logic [TX_CNT_W-1:0] r_tx_cnt;
    logic [7:0]          r_poll_cnt;
    logic [7:0]          r_rx_cnt;
    logic                r_pending;

    logic       w_issue;
    logic       w_accept;
    logic       w_rx_stb;
    logic [7:0] w_tx_byte;
    logic [7:0] w_crc_byte;

    // A new byte may be requested only when nothing is queued or in flight.
    assign w_issue  = !o_ll_stb && !r_pending;
    assign w_accept = o_ll_stb && i_ll_idle;
    assign w_rx_stb = r_pending && i_ll_stb;

`ifdef SDSPI_CMD_CRC7_EN
    logic [6:0] r_crc;
    logic [6:0] w_crc_next;

    sdspi_crc7 u_crc7 (
        .i_data (w_tx_byte),
        .i_crc  (r_crc),
        .o_crc  (w_crc_next)
    );

    assign w_crc_byte = {r_crc, STOP_BIT};
`else
    assign w_crc_byte = {7'h7F, STOP_BIT};
`endif

    // Select the command-frame byte for the current TX position.
    always_comb begin
        w_tx_byte = POLL_BYTE;
        case (r_tx_cnt)
            3'd0:    w_tx_byte = cmd_token(r_cmd);
            3'd1:    w_tx_byte = r_arg[31:24];
            3'd2:    w_tx_byte = r_arg[23:16];
            3'd3:    w_tx_byte = r_arg[15:8];
            3'd4:    w_tx_byte = r_arg[7:0];
            default: w_tx_byte = w_crc_byte;
        endcase
    end

    // Sequencer FSM with registered outputs and byte-engine handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_arg      <= '0;
            r_extra    <= 1'b0;
            r_tx_cnt   <= '0;
            r_poll_cnt <= '0;
            r_rx_cnt   <= '0;
            r_pending  <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_r1       <= 8'hFF;
            o_rsp_data <= '0;
            o_timeout  <= 1'b0;
            o_ll_cs    <= 1'b0;
            o_ll_stb   <= 1'b0;
            o_ll_byte  <= 8'hFF;
`ifdef SDSPI_CMD_CRC7_EN
            r_crc      <= '0;
`endif
        end else begin
            o_done  <= 1'b0;
            o_ll_cs <= i_hold_cs;

            if (w_accept) begin
                o_ll_stb  <= 1'b0;
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_stb) begin
                        r_cmd      <= i_cmd;
                        r_arg      <= i_arg;
                        r_extra    <= i_rsp_extra;
                        r_tx_cnt   <= '0;
                        r_poll_cnt <= '0;
                        r_rx_cnt   <= '0;
                        r_pending  <= 1'b0;
                        o_timeout  <= 1'b0;
                        o_busy     <= 1'b1;
                        o_ll_cs    <= 1'b1;
`ifdef SDSPI_CMD_CRC7_EN
                        r_crc      <= '0;
`endif
                        r_state    <= ST_TX;
                    end
                end

                ST_TX: begin
                    o_ll_cs <= 1'b1;
                    if (w_issue) begin
                        o_ll_stb  <= 1'b1;
                        o_ll_byte <= w_tx_byte;
`ifdef SDSPI_CMD_CRC7_EN
                        if (r_tx_cnt < TX_LAST) begin
                            r_crc <= w_crc_next;
                        end
`endif
                    end
                    // Echo bytes during the frame carry no information.
                    if (w_rx_stb) begin
                        r_pending <= 1'b0;
                        r_tx_cnt  <= r_tx_cnt + TX_CNT_W'(1);
                        if (r_tx_cnt == TX_LAST) begin
                            r_state <= ST_POLL;
                        end
                    end
                end

                ST_POLL: begin
                    o_ll_cs <= 1'b1;
                    if (w_issue) begin
                        o_ll_stb  <= 1'b1;
                        o_ll_byte <= POLL_BYTE;
                    end
                    if (w_rx_stb) begin
                        r_pending <= 1'b0;
                        if (!i_ll_byte[7]) begin
                            o_r1 <= i_ll_byte;
                            if (r_extra) begin
                                r_state <= ST_RXDATA;
                            end else begin
                                o_done  <= 1'b1;
                                o_busy  <= 1'b0;
                                o_ll_cs <= i_hold_cs;
                                r_state <= ST_DONE;
                            end
                        end else begin
                            if (r_poll_cnt != CNT_MAX) begin
                                r_poll_cnt <= r_poll_cnt + 8'd1;
                            end
                            if (r_poll_cnt >= POLL_LAST) begin
                                o_r1      <= 8'hFF;
                                o_timeout <= 1'b1;
                                o_done    <= 1'b1;
                                o_busy    <= 1'b0;
                                o_ll_cs   <= i_hold_cs;
                                r_state   <= ST_DONE;
                            end
                        end
                    end
                end

                ST_RXDATA: begin
                    o_ll_cs <= 1'b1;
                    if (w_issue) begin
                        o_ll_stb  <= 1'b1;
                        o_ll_byte <= POLL_BYTE;
                    end
                    if (w_rx_stb) begin
                        r_pending  <= 1'b0;
                        o_rsp_data <= {o_rsp_data[23:0], i_ll_byte};
                        if (r_rx_cnt != CNT_MAX) begin
                            r_rx_cnt <= r_rx_cnt + 8'd1;
                        end
                        if (r_rx_cnt >= RX_LAST) begin
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                            o_ll_cs <= i_hold_cs;
                            r_state <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdspi_cmd_seq.sv
// Bench for sdspi_cmd_seq: a byte-engine model plus a frame-level
// reference of what should be sent and captured for each command.
module tb_sdspi_cmd_seq;

    localparam int unsigned MAX_POLL = 8;
`ifdef SDSPI_CMD_CRC7_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cmd_stb;
    logic [5:0]  i_cmd;
    logic [31:0] i_arg;
    logic        i_rsp_extra;
    logic        i_hold_cs;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_r1;
    logic [31:0] o_rsp_data;
    logic        o_timeout;
    logic        o_ll_cs;
    logic        o_ll_stb;
    logic [7:0]  o_ll_byte;
    logic        i_ll_idle;
    logic        i_ll_stb;
    logic [7:0]  i_ll_byte;

    sdspi_cmd_seq #(.MAX_POLL(MAX_POLL)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_cmd_stb   (i_cmd_stb),
        .i_cmd       (i_cmd),
        .i_arg       (i_arg),
        .i_rsp_extra (i_rsp_extra),
        .i_hold_cs   (i_hold_cs),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_r1        (o_r1),
        .o_rsp_data  (o_rsp_data),
        .o_timeout   (o_timeout),
        .o_ll_cs     (o_ll_cs),
        .o_ll_stb    (o_ll_stb),
        .o_ll_byte   (o_ll_byte),
        .i_ll_idle   (i_ll_idle),
        .i_ll_stb    (i_ll_stb),
        .i_ll_byte   (i_ll_byte)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Byte-engine model knobs and observations.
    int  idle_delay  = 0;
    int  rsp_lat     = 2;
    bit  spurious_en = 1'b0;
    bq_t rsp_q;
    bq_t tx_log;
    int  done_cnt  = 0;
    int  stab_err  = 0;
    int  proto_err = 0;

    // Reference state that persists across commands.
    logic [31:0] exp_rsp = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference CRC7 over the 40-bit command frame body.
    function automatic logic [7:0] crc_byte_ref(input logic [5:0] cmd, input logic [31:0] arg);
        logic [39:0] msg;
        logic [6:0]  crc;
        logic        fb;
        msg = {2'b01, cmd, arg};
        crc = 7'h0;
        for (int i = 39; i >= 0; i--) begin
            fb  = msg[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) crc = crc ^ 7'h09;
        end
        return {crc, 1'b1};
    endfunction

    // Byte engine: accepts requests, returns queued bytes after a latency,
    // checks request stability and optionally injects unexpected strobes.
    initial begin : byte_engine
        logic       prev_stb;
        logic [7:0] prev_byte;
        bit         in_flight;
        int         wait_c;
        int         stall;
        prev_stb  = 1'b0;
        prev_byte = 8'h00;
        in_flight = 1'b0;
        wait_c    = 0;
        stall     = 0;
        i_ll_idle = 1'b0;
        i_ll_stb  = 1'b0;
        i_ll_byte = 8'h00;
        forever begin
            @(posedge i_clk);
            #1;
            i_ll_stb = 1'b0;
            if (o_done) begin
                done_cnt++;
                if (o_busy) proto_err++;
            end
            if (prev_stb && i_ll_idle && !i_reset) begin
                tx_log.push_back(prev_byte);
                in_flight = 1'b1;
                wait_c    = rsp_lat;
                stall     = 0;
                if (o_ll_stb) proto_err++;
            end else if (prev_stb && o_ll_stb && (o_ll_byte !== prev_byte)) begin
                stab_err++;
            end
            if (!o_ll_cs) begin
                in_flight = 1'b0;
                stall     = 0;
            end
            if (in_flight) begin
                if (wait_c == 0) begin
                    i_ll_stb  = 1'b1;
                    i_ll_byte = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'hFF;
                    in_flight = 1'b0;
                end else begin
                    wait_c--;
                end
            end else if (spurious_en && ($urandom_range(0, 3) == 0)) begin
                i_ll_stb  = 1'b1;
                i_ll_byte = 8'($urandom_range(0, 127));
            end
            i_ll_idle = !in_flight && o_ll_stb && (stall >= idle_delay);
            if (o_ll_stb && !i_ll_idle) stall++;
            prev_stb  = o_ll_stb;
            prev_byte = o_ll_byte;
        end
    end

    // Run one command end to end and compare against the frame-level model.
    task automatic run_cmd(input string tag, input logic [5:0] cmd, input logic [31:0] arg,
                           input logic extra, input logic hold, input bq_t polls,
                           input bit disturb);
        bq_t         exp_tx;
        logic [7:0]  exp_r1;
        logic        exp_to;
        logic [7:0]  b;
        int          k;
        int          d0;
        bit          got;

        exp_tx = {};
        exp_tx.push_back({2'b01, cmd});
        exp_tx.push_back(arg[31:24]);
        exp_tx.push_back(arg[23:16]);
        exp_tx.push_back(arg[15:8]);
        exp_tx.push_back(arg[7:0]);
        exp_tx.push_back(CRC_EN ? crc_byte_ref(cmd, arg) : 8'hFF);
        exp_to = 1'b1;
        exp_r1 = 8'hFF;
        k      = 0;
        for (int i = 0; i < int'(MAX_POLL); i++) begin
            b = (i < polls.size()) ? polls[i] : 8'hFF;
            exp_tx.push_back(8'hFF);
            if (!b[7]) begin
                exp_r1 = b;
                exp_to = 1'b0;
                k      = i;
                break;
            end
        end
        if (!exp_to && extra) begin
            for (int j = 0; j < 4; j++) begin
                exp_tx.push_back(8'hFF);
                b = ((k + 1 + j) < polls.size()) ? polls[k + 1 + j] : 8'hFF;
                exp_rsp = {exp_rsp[23:0], b};
            end
        end

        rsp_q = {};
        for (int i = 0; i < 6; i++) rsp_q.push_back(8'($urandom));
        foreach (polls[i]) rsp_q.push_back(polls[i]);
        tx_log = {};
        d0 = done_cnt;

        i_cmd       = cmd;
        i_arg       = arg;
        i_rsp_extra = extra;
        i_hold_cs   = hold;
        i_cmd_stb   = 1'b1;
        @(posedge i_clk); #2;
        i_cmd_stb   = 1'b0;
        i_cmd       = 6'($urandom);
        i_arg       = $urandom;
        i_rsp_extra = ~extra;
        chk({tag, "_busy_start"}, 32'(o_busy), 32'h1);
        chk({tag, "_to_clear"}, 32'(o_timeout), 32'h0);

        if (disturb) begin
            repeat (7) begin @(posedge i_clk); #2; end
            i_cmd_stb = 1'b1;
            @(posedge i_clk); #2;
            i_cmd_stb = 1'b0;
        end

        got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (o_done) begin
                got = 1'b1;
                break;
            end
            @(posedge i_clk); #2;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'h1);
        if (got) begin
            chk({tag, "_busy_at_done"}, 32'(o_busy), 32'h0);
            chk({tag, "_r1"}, 32'(o_r1), 32'(exp_r1));
            chk({tag, "_timeout"}, 32'(o_timeout), 32'(exp_to));
            chk({tag, "_rsp"}, o_rsp_data, exp_rsp);
            chk({tag, "_cs_at_done"}, 32'(o_ll_cs), 32'(hold));
            if (disturb) i_cmd_stb = 1'b1;
            @(posedge i_clk); #2;
            i_cmd_stb = 1'b0;
            chk({tag, "_done_pulse"}, 32'(o_done), 32'h0);
            chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'h1);
            @(posedge i_clk); #2;
            chk({tag, "_idle_busy"}, 32'(o_busy), 32'h0);
            chk({tag, "_cs_idle"}, 32'(o_ll_cs), 32'(hold));
            chk({tag, "_r1_hold"}, 32'(o_r1), 32'(exp_r1));
            chk({tag, "_tx_count"}, 32'(tx_log.size()), 32'(exp_tx.size()));
            for (int i = 0; i < exp_tx.size(); i++) begin
                chk($sformatf("%s_tx%0d", tag, i),
                    (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hDEAD,
                    32'(exp_tx[i]));
            end
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bq_t        p;
        logic [7:0] last;
        bit         reached;
        int         d0;
        int         nff;

        i_reset     = 1'b1;
        i_cmd_stb   = 1'b0;
        i_cmd       = 6'h0;
        i_arg       = 32'h0;
        i_rsp_extra = 1'b0;
        i_hold_cs   = 1'b0;
        repeat (3) @(posedge i_clk);
        #2;
        chk("rst_busy",   32'(o_busy),    32'h0);
        chk("rst_done",   32'(o_done),    32'h0);
        chk("rst_ll_stb", 32'(o_ll_stb),  32'h0);
        chk("rst_ll_cs",  32'(o_ll_cs),   32'h0);
        chk("rst_ll_byte",32'(o_ll_byte), 32'hFF);
        chk("rst_r1",     32'(o_r1),      32'hFF);
        chk("rst_rsp",    o_rsp_data,     32'h0);
        chk("rst_timeout",32'(o_timeout), 32'h0);
        i_reset = 1'b0;
        @(posedge i_clk); #2;

        // CMD0, two 0xFF polls then R1 = 0x01.
        p = {8'hFF, 8'hFF, 8'h01};
        run_cmd("cmd0", 6'd0, 32'h0, 1'b0, 1'b0, p, 1'b0);
        last = (tx_log.size() > 5) ? tx_log[5] : 8'h00;
        chk("cmd0_last_byte", 32'(last), CRC_EN ? 32'h95 : 32'hFF);

        // CMD8 with R7 payload.
        p = {8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        run_cmd("cmd8", 6'd8, 32'h0000_01AA, 1'b1, 1'b0, p, 1'b0);
        last = (tx_log.size() > 5) ? tx_log[5] : 8'h00;
        chk("cmd8_last_byte", 32'(last), CRC_EN ? 32'h87 : 32'hFF);
        chk("cmd8_rsp_const", o_rsp_data, 32'h0000_01AA);

        // No R1 ever: timeout after MAX_POLL polls, extra data ignored.
        p = {};
        run_cmd("tmo", 6'd55, 32'h1234_5678, 1'b1, 1'b1, p, 1'b0);
        chk("tmo_poll_count", 32'(tx_log.size()), 32'(6 + MAX_POLL));

        // Slow engine, repeated command strobes mid-command and in DONE.
        idle_delay = 5;
        p = {8'hFF, 8'h05};
        run_cmd("slow", 6'($urandom), $urandom, 1'b0, 1'b1, p, 1'b1);
        chk("slow_stable", 32'(stab_err), 32'h0);
        idle_delay = 0;

        // Reset while the third frame byte is outstanding.
        rsp_q = {};
        for (int i = 0; i < 6; i++) rsp_q.push_back(8'hFF);
        rsp_q.push_back(8'h01);
        tx_log = {};
        d0 = done_cnt;
        i_hold_cs = 1'b0;
        i_cmd     = 6'd17;
        i_arg     = 32'hCAFE_0001;
        i_cmd_stb = 1'b1;
        @(posedge i_clk); #2;
        i_cmd_stb = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (tx_log.size() >= 3) begin
                reached = 1'b1;
                break;
            end
            @(posedge i_clk); #2;
        end
        chk("rst_mid_reached", 32'(reached), 32'h1);
        i_reset = 1'b1;
        @(posedge i_clk); #2;
        i_reset = 1'b0;
        exp_rsp = 32'h0;
        chk("rst_mid_busy",   32'(o_busy),   32'h0);
        chk("rst_mid_ll_stb", 32'(o_ll_stb), 32'h0);
        chk("rst_mid_ll_cs",  32'(o_ll_cs),  32'h0);
        chk("rst_mid_r1",     32'(o_r1),     32'hFF);
        repeat (20) begin @(posedge i_clk); #2; end
        chk("rst_mid_no_done", 32'(done_cnt - d0), 32'h0);
        chk("rst_mid_idle",    32'(o_busy),        32'h0);
        p = {8'hFF, 8'hFF, 8'h01};
        run_cmd("cmd0_after_rst", 6'd0, 32'h0, 1'b0, 1'b0, p, 1'b0);

        // Randomized commands, engine timing and unexpected strobes.
        for (int n = 0; n < 10; n++) begin
            idle_delay  = $urandom_range(0, 3);
            rsp_lat     = $urandom_range(0, 3);
            spurious_en = 1'($urandom_range(0, 1));
            nff = $urandom_range(0, MAX_POLL + 1);
            p = {};
            for (int i = 0; i < nff; i++) p.push_back(8'h80 | 8'($urandom));
            p.push_back(8'($urandom_range(0, 127)));
            for (int i = 0; i < 4; i++) p.push_back(8'($urandom));
            run_cmd($sformatf("rnd%0d", n), 6'($urandom), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p, 1'b0);
        end
        spurious_en = 1'b0;

        chk("stable_total", 32'(stab_err),  32'h0);
        chk("protocol",     32'(proto_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
